// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared core enums for PC source selection and branch type.
// Revision    : 1.0
// ============================================================================
package core_pkg;

  typedef enum logic [1:0] {
    PC_NEXT   = 2'd0,
    PC_JUMP   = 2'd1,
    PC_BRANCH = 2'd2,
    PC_TRAP   = 2'd3
  } pc_src_e;

  typedef enum logic {
    BRANCH_NZ = 1'b0,
    BRANCH_Z  = 1'b1
  } br_type_e;

endpackage
`default_nettype wire

// File: rtl/core_pc_redirect_if.sv
`default_nettype none
// ============================================================================
// Module      : core_pc_redirect_if
// Description : EX/trap request bundle and fetch redirect handshake.
// Revision    : 1.0
// ============================================================================
interface core_pc_redirect_if #(
  parameter int XLEN = 32
);

  logic                ex_valid;
  core_pkg::pc_src_e   pc_src;
  core_pkg::br_type_e  br_type;
  logic [XLEN-1:0]     alu_result;
  logic [XLEN-1:0]     br_target;
  logic                trap_valid;
  logic [XLEN-1:0]     trap_target;
  logic                redirect_ready;
  logic                redirect_valid;
  logic [XLEN-1:0]     redirect_pc;
  logic                flush;
  logic                ex_stall;
  logic                exc_misaligned;
  logic [XLEN-1:0]     exc_tval;

  modport slave (
    input  ex_valid, pc_src, br_type, alu_result, br_target,
    input  trap_valid, trap_target, redirect_ready,
    output redirect_valid, redirect_pc, flush, ex_stall,
    output exc_misaligned, exc_tval
  );

  modport master (
    output ex_valid, pc_src, br_type, alu_result, br_target,
    output trap_valid, trap_target, redirect_ready,
    input  redirect_valid, redirect_pc, flush, ex_stall,
    input  exc_misaligned, exc_tval
  );

endinterface
`default_nettype wire

// File: rtl/core_pc_redirect.sv
`default_nettype none
// ============================================================================
// Module      : core_pc_redirect
// Description : EX-stage PC redirect unit: boot vector, jumps, branches and
//               traps folded into one held valid/ready request to fetch.
//               CORE_RVC_EN relaxes target alignment to 2 bytes.
// Revision    : 1.0
// ============================================================================
module core_pc_redirect #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               rst,
  core_pc_redirect_if.slave  bus
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic            exc_q, exc_d;

  logic            taken;
  logic            misaligned;
  logic            capture;
  logic [XLEN-1:0] target;

  always_comb begin
    taken  = 1'b0;
    target = bus.br_target;
    if (bus.ex_valid) begin
      case (bus.pc_src)
        core_pkg::PC_JUMP: begin
          taken  = 1'b1;
          target = {bus.alu_result[XLEN-1:1], 1'b0};
        end
        core_pkg::PC_BRANCH: begin
          if (bus.br_type == core_pkg::BRANCH_Z) taken = (bus.alu_result == '0);
          else                                   taken = (bus.alu_result != '0);
        end
        default: taken = 1'b0;
      endcase
    end
  end

`ifdef CORE_RVC_EN
  assign misaligned = target[0];
`else
  assign misaligned = |target[1:0];
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tval_d  = tval_q;
    exc_d   = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_BOOT: begin
        if (bus.redirect_ready) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.trap_valid) begin
          capture = 1'b1;
          pc_d    = bus.trap_target;
          state_d = ST_PEND;
        end else if (taken && !misaligned) begin
          capture = 1'b1;
          pc_d    = target;
          state_d = ST_PEND;
        end else if (taken) begin
          exc_d  = 1'b1;
          tval_d = target;
        end
      end
      ST_PEND: begin
        // A trap replaces the offered PC; the old one may still transfer this edge.
        if (bus.trap_valid) begin
          capture = 1'b1;
          pc_d    = bus.trap_target;
        end else if (bus.redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      exc_q   <= 1'b0;
      tval_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      exc_q   <= exc_d;
      tval_q  <= tval_d;
    end
  end

  assign bus.redirect_valid = (state_q != ST_IDLE);
  assign bus.redirect_pc    = pc_q;
  assign bus.flush          = capture;
  assign bus.ex_stall       = (state_q == ST_BOOT) ||
                              ((state_q == ST_PEND) && !bus.redirect_ready);
  assign bus.exc_misaligned = exc_q;
  assign bus.exc_tval       = tval_q;

endmodule
`default_nettype wire

// File: tb/tb_core_pc_redirect.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_pc_redirect
// Description : Directed self-checking bench; accepted redirects are checked
//               against a queue of expected PCs.
// Revision    : 1.0
// ============================================================================
module tb_core_pc_redirect;

  localparam logic [31:0] RV = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] exp_q[$];

  core_pc_redirect_if #(.XLEN(32)) bus ();

  core_pc_redirect #(.XLEN(32), .RESET_VECTOR(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.ex_valid    = 1'b0;
    bus.pc_src      = core_pkg::PC_NEXT;
    bus.br_type     = core_pkg::BRANCH_NZ;
    bus.alu_result  = '0;
    bus.br_target   = '0;
    bus.trap_valid  = 1'b0;
    bus.trap_target = '0;
  endtask

  task automatic do_jump(input logic [31:0] alu);
    bus.ex_valid   = 1'b1;
    bus.pc_src     = core_pkg::PC_JUMP;
    bus.alu_result = alu;
  endtask

  // Every accepted transfer must match the oldest expected PC.
  always @(negedge clk) begin
    if (!rst && bus.redirect_valid && bus.redirect_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_transfer", bus.redirect_pc, 32'hxxxx_xxxx);
      end else begin
        chk("transfer_pc", bus.redirect_pc, exp_q.pop_front());
      end
    end
  end

  initial begin
    idle_inputs();
    bus.redirect_ready = 1'b0;
    cyc();
    mid();
    chk("rst_valid", {31'd0, bus.redirect_valid}, 32'd1);
    chk("rst_pc", bus.redirect_pc, RV);
    chk("rst_exc", {31'd0, bus.exc_misaligned}, 32'd0);
    chk("rst_tval", bus.exc_tval, 32'd0);
    chk("rst_flush", {31'd0, bus.flush}, 32'd0);
    chk("rst_stall", {31'd0, bus.ex_stall}, 32'd1);
    cyc();
    rst = 1'b0;
    exp_q.push_back(RV);

    // Boot: trap and jump are ignored, vector held until ready.
    bus.trap_valid  = 1'b1;
    bus.trap_target = 32'h0000_0300;
    do_jump(32'h0000_0040);
    mid();
    chk("boot_flush_c1", {31'd0, bus.flush}, 32'd0);
    chk("boot_pc_c1", bus.redirect_pc, RV);
    cyc();
    idle_inputs();
    mid();
    chk("boot_valid_c2", {31'd0, bus.redirect_valid}, 32'd1);
    chk("boot_pc_c2", bus.redirect_pc, RV);
    cyc();
    bus.redirect_ready = 1'b1;
    mid();
    chk("boot_flush_c3", {31'd0, bus.flush}, 32'd0);
    cyc();
    mid();
    chk("idle_valid", {31'd0, bus.redirect_valid}, 32'd0);
    chk("idle_stall", {31'd0, bus.ex_stall}, 32'd0);

    // Jump: bit 0 cleared, flush same cycle, redirect next cycle.
    cyc();
    do_jump(32'h0000_1235);
    mid();
    chk("jump_flush", {31'd0, bus.flush}, 32'd1);
    exp_q.push_back(32'h0000_1234);
    cyc();
    idle_inputs();
    mid();
    chk("jump_valid", {31'd0, bus.redirect_valid}, 32'd1);
    chk("jump_flush_n1", {31'd0, bus.flush}, 32'd0);
    cyc();

    // Branch NZ with zero compare: not taken.
    bus.ex_valid   = 1'b1;
    bus.pc_src     = core_pkg::PC_BRANCH;
    bus.br_type    = core_pkg::BRANCH_NZ;
    bus.alu_result = '0;
    bus.br_target  = 32'h0000_0180;
    mid();
    chk("bnz_flush", {31'd0, bus.flush}, 32'd0);
    cyc();
    idle_inputs();
    mid();
    chk("bnz_valid", {31'd0, bus.redirect_valid}, 32'd0);

    // Branch Z with zero compare: taken to br_target.
    cyc();
    bus.ex_valid   = 1'b1;
    bus.pc_src     = core_pkg::PC_BRANCH;
    bus.br_type    = core_pkg::BRANCH_Z;
    bus.alu_result = '0;
    bus.br_target  = 32'h0000_0100;
    mid();
    chk("bz_flush", {31'd0, bus.flush}, 32'd1);
    exp_q.push_back(32'h0000_0100);
    cyc();
    idle_inputs();
    mid();
    chk("bz_valid", {31'd0, bus.redirect_valid}, 32'd1);
    cyc();

    // Jump to a 2-byte aligned target.
    do_jump(32'h0000_0102);
    mid();
`ifdef CORE_RVC_EN
    chk("j102_flush", {31'd0, bus.flush}, 32'd1);
    exp_q.push_back(32'h0000_0102);
    cyc();
    idle_inputs();
    mid();
    chk("j102_exc", {31'd0, bus.exc_misaligned}, 32'd0);
    chk("j102_valid", {31'd0, bus.redirect_valid}, 32'd1);
    cyc();
`else
    chk("j102_flush", {31'd0, bus.flush}, 32'd0);
    cyc();
    idle_inputs();
    mid();
    chk("j102_exc", {31'd0, bus.exc_misaligned}, 32'd1);
    chk("j102_tval", bus.exc_tval, 32'h0000_0102);
    chk("j102_valid", {31'd0, bus.redirect_valid}, 32'd0);
    cyc();
    mid();
    chk("j102_exc_off", {31'd0, bus.exc_misaligned}, 32'd0);
    cyc();
`endif

    // Odd branch target is misaligned in both builds.
    bus.ex_valid   = 1'b1;
    bus.pc_src     = core_pkg::PC_BRANCH;
    bus.br_type    = core_pkg::BRANCH_NZ;
    bus.alu_result = 32'd1;
    bus.br_target  = 32'h0000_0201;
    mid();
    chk("bodd_flush", {31'd0, bus.flush}, 32'd0);
    cyc();
    idle_inputs();
    mid();
    chk("bodd_exc", {31'd0, bus.exc_misaligned}, 32'd1);
    chk("bodd_tval", bus.exc_tval, 32'h0000_0201);
    cyc();
    mid();
    chk("bodd_exc_off", {31'd0, bus.exc_misaligned}, 32'd0);

    // Pending with ready low; trap overwrites in cycle 2.
    cyc();
    bus.redirect_ready = 1'b0;
    do_jump(32'h0000_0400);
    mid();
    chk("pend_flush", {31'd0, bus.flush}, 32'd1);
    cyc();
    idle_inputs();
    mid();
    chk("pend_stall_c1", {31'd0, bus.ex_stall}, 32'd1);
    chk("pend_pc_c1", bus.redirect_pc, 32'h0000_0400);
    cyc();
    bus.trap_valid  = 1'b1;
    bus.trap_target = 32'h0000_0200;
    mid();
    chk("trap_flush", {31'd0, bus.flush}, 32'd1);
    chk("pend_pc_c2", bus.redirect_pc, 32'h0000_0400);
    exp_q.push_back(32'h0000_0200);
    cyc();
    idle_inputs();
    mid();
    chk("pend_stall_c3", {31'd0, bus.ex_stall}, 32'd1);
    chk("pend_pc_c3", bus.redirect_pc, 32'h0000_0200);
    cyc();
    bus.redirect_ready = 1'b1;
    mid();
    chk("pend_stall_rdy", {31'd0, bus.ex_stall}, 32'd0);
    cyc();
    mid();
    chk("pend_done_valid", {31'd0, bus.redirect_valid}, 32'd0);

    // Trap capture on the same edge the old PC is accepted.
    cyc();
    bus.redirect_ready = 1'b0;
    do_jump(32'h0000_0500);
    exp_q.push_back(32'h0000_0500);
    cyc();
    idle_inputs();
    bus.redirect_ready = 1'b1;
    bus.trap_valid     = 1'b1;
    bus.trap_target    = 32'h0000_0600;
    exp_q.push_back(32'h0000_0600);
    mid();
    chk("simul_flush", {31'd0, bus.flush}, 32'd1);
    cyc();
    idle_inputs();
    mid();
    chk("simul_valid", {31'd0, bus.redirect_valid}, 32'd1);
    chk("simul_pc", bus.redirect_pc, 32'h0000_0600);
    cyc();
    mid();
    chk("simul_done", {31'd0, bus.redirect_valid}, 32'd0);

    // Reset while pending discards the target.
    cyc();
    bus.redirect_ready = 1'b0;
    do_jump(32'h0000_0700);
    cyc();
    idle_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    mid();
    chk("rstp_valid", {31'd0, bus.redirect_valid}, 32'd1);
    chk("rstp_pc", bus.redirect_pc, RV);
    chk("rstp_stall", {31'd0, bus.ex_stall}, 32'd1);
    exp_q.push_back(RV);
    cyc();
    bus.redirect_ready = 1'b1;
    cyc();
    mid();
    chk("rstp_idle", {31'd0, bus.redirect_valid}, 32'd0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
